// File: rtl/pulse_stretcher_pkg.sv
// Shared types and default widths for the pulse stretcher.
// Holds the FSM state encoding used by the top level.
package pulse_stretcher_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int EVT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } ps_state_t;

endpackage

// File: rtl/pulse_stretch_cnt.sv
// Loadable down-counter with zero flag.
// Load has priority over decrement.
module pulse_stretch_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Retriggerable pulse stretcher with holdoff and event counter.
// All outputs come straight from flops fed by next-state logic.
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int EVT_W = EVT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] len,
  input  logic [CNT_W-1:0] holdoff,
  input  logic             retrig_en,
  output logic             level_out,
  output logic             busy,
  output logic             overrun,
  output logic [EVT_W-1:0] evt_cnt
);

  ps_state_t        state, state_next;
  logic             load, dec, zero;
  logic             accept, ovr;
  logic [CNT_W-1:0] load_val, cnt;
  logic             len_ok, seamless;

  pulse_stretch_cnt #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (zero)
  );

  assign len_ok   = (len != '0);
  assign seamless = zero && (holdoff == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_val   = '0;
    dec        = 1'b0;
    accept     = 1'b0;
    ovr        = 1'b0;
    unique case (state)
      IDLE: begin
        if (pulse_in && len_ok) begin
          accept     = 1'b1;
          load       = 1'b1;
          load_val   = len - CNT_W'(1);
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pulse_in && len_ok && (retrig_en || seamless)) begin
          accept   = 1'b1;
          load     = 1'b1;
          load_val = len - CNT_W'(1);
        end else begin
          ovr = pulse_in;
          if (!zero) begin
            dec = 1'b1;
          end else if (holdoff != '0) begin
            load       = 1'b1;
            load_val   = holdoff - CNT_W'(1);
            state_next = HOLDOFF;
          end else begin
            state_next = IDLE;
          end
        end
      end
      HOLDOFF: begin
        ovr = pulse_in;
        if (zero) begin
          state_next = IDLE;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs register the upcoming state so they align with the state flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_out <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      level_out <= (state_next == ACTIVE);
      busy      <= (state_next != IDLE);
      overrun   <= ovr;
      if (accept && (evt_cnt != '1)) begin
        evt_cnt <= evt_cnt + EVT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed self-checking bench for pulse_stretcher.
// Vector bit i holds the output seen just after clock edge i.
module tb_pulse_stretcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pulse_in = 1'b0;
  logic [7:0]  len = '0;
  logic [7:0]  holdoff = '0;
  logic        retrig_en = 1'b0;
  logic        level_out, busy, overrun;
  logic [15:0] evt_cnt;
  logic        level2, busy2, overrun2;
  logic [1:0]  evt2;

  int checks = 0;
  int failures = 0;

  logic [31:0] lv, ov;

  pulse_stretcher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .len       (len),
    .holdoff   (holdoff),
    .retrig_en (retrig_en),
    .level_out (level_out),
    .busy      (busy),
    .overrun   (overrun),
    .evt_cnt   (evt_cnt)
  );

  pulse_stretcher #(.EVT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse_in  (pulse_in),
    .len       (len),
    .holdoff   (holdoff),
    .retrig_en (retrig_en),
    .level_out (level2),
    .busy      (busy2),
    .overrun   (overrun2),
    .evt_cnt   (evt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pulse_in = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic run(input int n, input logic [31:0] pmask,
                     output logic [31:0] lvv, output logic [31:0] ovv);
    lvv = '0;
    ovv = '0;
    for (int i = 0; i < n; i++) begin
      pulse_in = pmask[i];
      tick();
      pulse_in = 1'b0;
      lvv[i] = level_out;
      ovv[i] = overrun;
    end
  endtask

  initial begin
    do_reset();
    chk("rst_level", 32'(level_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_evt", 32'(evt_cnt), 32'd0);

    // single pulse, len=3
    len = 8'd3; holdoff = 8'd0; retrig_en = 1'b0;
    run(12, 32'h20, lv, ov);
    chk("single_lv", lv, 32'h0E0);
    chk("single_ov", ov, 32'h0);
    chk("single_evt", 32'(evt_cnt), 32'd1);

    // retrigger extends the stretch
    do_reset();
    len = 8'd4; retrig_en = 1'b1;
    run(10, 32'h5, lv, ov);
    chk("retrig_lv", lv, 32'h3F);
    chk("retrig_ov", ov, 32'h0);
    chk("retrig_evt", 32'(evt_cnt), 32'd2);

    // no retrigger, holdoff=2
    do_reset();
    len = 8'd4; retrig_en = 1'b0; holdoff = 8'd2;
    run(10, 32'h25, lv, ov);
    chk("hold_lv", lv, 32'hF);
    chk("hold_ov", ov, 32'h24);
    chk("hold_evt", 32'(evt_cnt), 32'd1);
    chk("hold_busy", 32'(busy), 32'd0);

    // seamless on the last ACTIVE cycle
    do_reset();
    len = 8'd2; holdoff = 8'd0; retrig_en = 1'b0;
    run(8, 32'h5, lv, ov);
    chk("seam_lv", lv, 32'hF);
    chk("seam_ov", ov, 32'h0);
    chk("seam_evt", 32'(evt_cnt), 32'd2);

    // len=0 is ignored
    do_reset();
    len = 8'd0;
    run(4, 32'h1, lv, ov);
    chk("len0_lv", lv, 32'h0);
    chk("len0_ov", ov, 32'h0);
    chk("len0_busy", 32'(busy), 32'd0);
    chk("len0_evt", 32'(evt_cnt), 32'd0);

    // len change mid-stretch has no effect
    do_reset();
    len = 8'd3;
    pulse_in = 1'b1;
    tick();
    pulse_in = 1'b0;
    chk("lchg_first", 32'(level_out), 32'd1);
    len = 8'd7;
    run(8, 32'h0, lv, ov);
    chk("lchg_lv", lv, 32'h3);

    // retrigger with len=0 strobes overrun
    do_reset();
    len = 8'd3; retrig_en = 1'b1;
    pulse_in = 1'b1;
    tick();
    len = 8'd0;
    run(6, 32'h1, lv, ov);
    chk("rl0_lv", lv, 32'h3);
    chk("rl0_ov", ov, 32'h1);
    chk("rl0_evt", 32'(evt_cnt), 32'd1);

    // asynchronous reset mid-stretch
    do_reset();
    len = 8'd5; retrig_en = 1'b0;
    run(2, 32'h1, lv, ov);
    chk("arst_pre", 32'(level_out), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_level", 32'(level_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_evt", 32'(evt_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    len = 8'd1;
    run(4, 32'h1, lv, ov);
    chk("arst_len1_lv", lv, 32'h1);
    chk("arst_evt1", 32'(evt_cnt), 32'd1);

    // saturation of a 2-bit counter
    do_reset();
    len = 8'd1; holdoff = 8'd0;
    run(10, 32'h155, lv, ov);
    chk("sat_evt2", 32'(evt2), 32'd3);
    chk("sat_evt16", 32'(evt_cnt), 32'd5);
    chk("sat_lv", lv, 32'h155);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_stretcher.md
PULSE_STRETCHER -- requirements
Module: pulse_stretcher

Interface
REQ-001 Parameter CNT_W, default 8: width of the len, holdoff and internal down-counter.
REQ-002 Parameter EVT_W, default 16: width of the accepted-pulse counter.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; assertion is asynchronous, release is on a clk edge.
REQ-005 pulse_in  input  1  single-cycle trigger pulse, as produced by the team's pulse generator.
REQ-006 len  input  CNT_W  stretch length in cycles; sampled when a trigger is accepted.
REQ-007 holdoff  input  CNT_W  dead time in cycles after a stretch ends; sampled when a stretch ends.
REQ-008 retrig_en  input  1  when 1, a trigger during a stretch restarts that stretch.
REQ-009 level_out  output  1  registered stretched level.
REQ-010 busy  output  1  high when the state is not IDLE.
REQ-011 overrun  output  1  one-cycle strobe; marks a trigger that was not accepted.
REQ-012 evt_cnt  output  EVT_W  count of accepted triggers; saturates at its maximum value.

Function
REQ-013 The state machine SHALL have three states: IDLE, ACTIVE and HOLDOFF.
REQ-014 IDLE: level_out=0; on pulse_in=1 with len!=0 the block SHALL load cnt=len-1, go to ACTIVE and increment evt_cnt.
REQ-015 IDLE with pulse_in=1 and len=0: the trigger SHALL be ignored (no state change, no overrun, evt_cnt unchanged).
REQ-016 Latency: for a trigger sampled at edge N, level_out SHALL be high for exactly len cycles, from edge N to edge N+len.
REQ-017 ACTIVE: level_out=1; if cnt!=0 the block SHALL decrement cnt each cycle.
REQ-018 ACTIVE with cnt=0 (last cycle): go to HOLDOFF with cnt=holdoff-1 if holdoff!=0, else go to IDLE.
REQ-019 ACTIVE with pulse_in=1, retrig_en=1, len!=0: the block SHALL reload cnt=len-1, stay in ACTIVE, increment evt_cnt, and keep level_out high without a gap.
REQ-020 ACTIVE with pulse_in=1, retrig_en=0, not the last cycle: the block SHALL assert overrun for one cycle; cnt is unaffected.
REQ-021 Last ACTIVE cycle (cnt=0), holdoff=0, pulse_in=1, len!=0: the block SHALL accept a new stretch seamlessly (reload, stay ACTIVE, count it) regardless of retrig_en.
REQ-022 HOLDOFF: level_out=0; cnt SHALL decrement each cycle; on cnt=0 the block SHALL go to IDLE.
REQ-023 HOLDOFF with pulse_in=1: the block SHALL assert overrun for one cycle and ignore the trigger, including on the final HOLDOFF cycle.
REQ-024 evt_cnt SHALL saturate at 2^EVT_W-1 and never wrap.
REQ-025 A retrigger with len=0 SHALL be treated as non-accepted: overrun strobes and the stretch continues.
REQ-026 Changes to len or holdoff outside their sampling points SHALL have no effect on a stretch already in progress.

Reset
REQ-027 While rst_n=0: state=IDLE, cnt=0, level_out=0, busy=0, overrun=0, evt_cnt=0.
REQ-028 Reset asserted mid-stretch or mid-holdoff SHALL force level_out low immediately (asynchronously); no stretch resumes after release.
REQ-029 The first trigger SHALL be accepted on the first clk edge after rst_n is released.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE/ACTIVE/HOLDOFF) and the default CNT_W/EVT_W constants.
REQ-031 One sub-module, pulse_stretch_cnt, SHALL implement the loadable down-counter with a zero flag; the FSM SHALL remain in the top level.
REQ-032 Every output SHALL be driven directly from a flop.

Verification
REQ-033 len=3, holdoff=0, single pulse at edge 5 -> level_out high for edges 5..7, low at 8; evt_cnt=1; overrun never asserts.
REQ-034 len=4, retrig_en=1, pulses at edges 0 and 2 -> level_out high for 6 continuous cycles; evt_cnt=2.
REQ-035 len=4, retrig_en=0, holdoff=2, pulses at edges 0, 2 and 5 -> level high for 4 cycles; overrun asserts on the cycles after edges 2 and 5; evt_cnt=1.
REQ-036 len=2, holdoff=0, pulse on the last ACTIVE cycle -> level_out high for 4 cycles with no gap; evt_cnt=2.
REQ-037 len=0 pulse -> no level, busy=0, evt_cnt=0; separately, rst_n low mid-stretch -> level_out=0 immediately, and after release a pulse with len=1 gives a 1-cycle level.
REQ-038 EVT_W=2, five accepted pulses -> evt_cnt saturates at 3.
